alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
- Multi-cycle issue/collect controller that sits on the driving side of the 32-bit datapath ALU.
- Accepts a decoded operation request (ALUOp class, funct, shamt, two operands) over a valid/ready handshake.
- Translates the request into the ALU's 3-bit operation code and operand pair, waits a programmable settle time, then captures res/zero/overflow.
- Returns the result to the requester over a second valid/ready handshake, flagging illegal functs and signed-overflow traps.

Parameters:
- ALU_LAT, 1, number of clock cycles the ALU inputs are held before capture (legal range 1..15).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_class  in  2  ALUOp class: 00 add, 01 sub, 10 R-type (use funct), 11 slt.
- req_funct  in  6  R-type funct field, used only when class=10.
- req_shamt  in  5  shift amount, used for srl.
- req_a  in  32  operand rs.
- req_b  in  32  operand rt/immediate.
- alu_a  out  32  ALU operand A (registered).
- alu_b  out  32  ALU operand B (registered).
- alu_op  out  3  ALU operation code (registered).
- alu_res  in  32  ALU result.
- alu_zero  in  1  ALU zero flag.
- alu_overflow  in  1  ALU add/sub overflow output.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts response.
- rsp_res  out  32  captured result.
- rsp_zero  out  1  captured zero flag.
- rsp_ovf_trap  out  1  signed add/sub overflow trap.
- rsp_illegal  out  1  unsupported funct, no ALU issue.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0 except req_ready=1. Reset mid-operation aborts with no response and no partial capture.
- States: IDLE, EXEC, RESP.
- req_ready=1 only in IDLE. Acceptance is req_valid & req_ready at a rising edge.
- Decode to alu_op:
  - class 00 -> 010 (add).
  - class 01 -> 110 (sub).
  - class 11 -> 111 (slt).
  - class 10, by funct:
    - 100000/100001 -> 010
    - 100010/100011 -> 110
    - 100100 -> 000
    - 100101 -> 001
    - 100110 -> 011
    - 100111 -> 100
    - 101010 -> 111
    - 000010 -> 101 (srl)
  - Any other funct with class 10 is illegal.
- Operand mapping:
  - Non-shift ops: alu_a=req_a, alu_b=req_b.
  - srl: alu_a=req_b (rt), alu_b={21'b0, req_shamt, 6'b0}, because the ALU takes its shift amount from B[10:6].
- IDLE -> EXEC on legal acceptance: alu_a/alu_b/alu_op are loaded at the acceptance edge, and a cycle counter is loaded with ALU_LAT-1.
- EXEC holds the ALU inputs stable for exactly ALU_LAT cycles. On the edge ending the last EXEC cycle:
  - capture alu_res -> rsp_res and alu_zero -> rsp_zero;
  - rsp_ovf_trap = alu_overflow only if class=10 and funct is 100000 or 100010, else 0;
  - rsp_illegal=0; state -> RESP.
- IDLE -> RESP directly on illegal acceptance: rsp_res=0, rsp_zero=0, rsp_ovf_trap=0, rsp_illegal=1. alu_* outputs are left unchanged.
- RESP: rsp_valid=1 and all rsp_* outputs are held stable. On rsp_valid & rsp_ready -> IDLE, and rsp_valid drops on the same edge.
- rsp_* hold their last values in IDLE/EXEC; only rsp_valid qualifies them. alu_* hold their last values outside EXEC.
- Latency: rsp_valid rises ALU_LAT+1 edges after acceptance for legal ops, and 1 edge after acceptance for illegal ops.
- Throughput: at most one request per ALU_LAT+2 cycles when rsp_ready is held at 1.
- Requests presented outside IDLE are not accepted; req_valid may stay high and is taken on return to IDLE.
- rsp_ready asserted outside RESP is ignored.

Test Plan:
- Reset then R-add: class=10, funct=100000, a=5, b=7, ALU_LAT=1 -> alu_op=010; rsp_valid 2 edges after accept; rsp_res=12, rsp_zero=0, trap=0, illegal=0.
- Sub to zero: class=01, a=b=0x1234 -> alu_op=110; rsp_res=0, rsp_zero=1, trap=0 (class 01 never traps even if alu_overflow=1).
- srl: class=10, funct=000010, b=0x8000_0000, shamt=4 -> alu_a=0x8000_0000, alu_b=0x0000_0100, alu_op=101; rsp_res=0x0800_0000.
- Illegal funct 001000 -> no EXEC cycle; rsp_valid after 1 edge with illegal=1, res=0; alu_* unchanged from the prior op.
- Backpressure and trap: add with alu_overflow forced 1, rsp_ready=0 for 5 cycles -> rsp_valid and rsp_ovf_trap=1 held stable, req_ready=0 throughout; rsp_ready=1 returns to IDLE next edge with req_ready=1.
- Async reset: with ALU_LAT=4, rst_n low in the 2nd EXEC cycle -> all outputs 0 immediately, req_ready=1 after release, and no rsp_valid pulse.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Issue/collect controller for the 32-bit datapath ALU. Decodes
//               a request into op code and operands, holds them for ALU_LAT
//               cycles, captures the result and returns it over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_class,
    input  logic [5:0]  req_funct,
    input  logic [4:0]  req_shamt,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_res,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_res,
    output logic        rsp_zero,
    output logic        rsp_ovf_trap,
    output logic        rsp_illegal,
    output logic        busy
);

    localparam logic [3:0] C_CNT_INIT = 4'(ALU_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    logic [2:0]  r_alu_op;
    logic        r_trap_en;
    logic [31:0] r_rsp_res;
    logic        r_rsp_zero;
    logic        r_rsp_ovf_trap;
    logic        r_rsp_illegal;
    logic        r_rsp_valid;
    logic        r_req_ready;
    logic        r_busy;

    logic [2:0]  w_op;
    logic        w_illegal;
    logic        w_srl;
    logic        w_trap_en;
    logic        w_accept;

    always_comb begin
        w_op      = 3'b010;
        w_illegal = 1'b0;
        w_srl     = 1'b0;
        w_trap_en = 1'b0;
        case (req_class)
            2'b00: w_op = 3'b010;
            2'b01: w_op = 3'b110;
            2'b11: w_op = 3'b111;
            default: begin
                case (req_funct)
                    6'b100000: begin w_op = 3'b010; w_trap_en = 1'b1; end
                    6'b100001: w_op = 3'b010;
                    6'b100010: begin w_op = 3'b110; w_trap_en = 1'b1; end
                    6'b100011: w_op = 3'b110;
                    6'b100100: w_op = 3'b000;
                    6'b100101: w_op = 3'b001;
                    6'b100110: w_op = 3'b011;
                    6'b100111: w_op = 3'b100;
                    6'b101010: w_op = 3'b111;
                    6'b000010: begin w_op = 3'b101; w_srl = 1'b1; end
                    default:   w_illegal = 1'b1;
                endcase
            end
        endcase
    end

    assign w_accept = req_valid & r_req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= 4'd0;
            r_alu_a        <= 32'd0;
            r_alu_b        <= 32'd0;
            r_alu_op       <= 3'd0;
            r_trap_en      <= 1'b0;
            r_rsp_res      <= 32'd0;
            r_rsp_zero     <= 1'b0;
            r_rsp_ovf_trap <= 1'b0;
            r_rsp_illegal  <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_req_ready    <= 1'b1;
            r_busy         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (w_illegal) begin
                            r_rsp_res      <= 32'd0;
                            r_rsp_zero     <= 1'b0;
                            r_rsp_ovf_trap <= 1'b0;
                            r_rsp_illegal  <= 1'b1;
                            r_rsp_valid    <= 1'b1;
                            r_state        <= S_RESP;
                        end else begin
                            // ALU reads its shift amount from B[10:6] and shifts A.
                            r_alu_a   <= w_srl ? req_b : req_a;
                            r_alu_b   <= w_srl ? {21'd0, req_shamt, 6'd0} : req_b;
                            r_alu_op  <= w_op;
                            r_trap_en <= w_trap_en;
                            r_cnt     <= C_CNT_INIT;
                            r_state   <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (r_cnt == 4'd0) begin
                        r_rsp_res      <= alu_res;
                        r_rsp_zero     <= alu_zero;
                        r_rsp_ovf_trap <= alu_overflow & r_trap_en;
                        r_rsp_illegal  <= 1'b0;
                        r_rsp_valid    <= 1'b1;
                        r_state        <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready    = r_req_ready;
    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_op       = r_alu_op;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_res      = r_rsp_res;
    assign rsp_zero     = r_rsp_zero;
    assign rsp_ovf_trap = r_rsp_ovf_trap;
    assign rsp_illegal  = r_rsp_illegal;
    assign busy         = r_busy;

endmodule
`default_nettype wire
